// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle control unit
package mc_pkg;

    typedef enum logic [3:0] {
        ST_IF     = 4'd0,
        ST_ID     = 4'd1,
        ST_EXE_AL = 4'd2,
        ST_WB_AL  = 4'd3,
        ST_EXE_BR = 4'd4,
        ST_EXE_LS = 4'd5,
        ST_MEM    = 4'd6,
        ST_WB_LD  = 4'd7,
        ST_HALT   = 4'd8
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_RTYPE, CLS_ADDIU, CLS_ORI, CLS_BEQ, CLS_BNE,
        CLS_LW, CLS_SW, CLS_J, CLS_JR, CLS_JAL, CLS_HALT
    } cls_t;

    typedef struct packed {
        logic       pc_wre;
        logic       ir_wre;
        logic       ins_mem_rw;
        logic       reg_wre;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       ext_sel;
        logic [1:0] reg_dst;
        logic       wr_reg_d_src;
        logic       db_data_src;
        logic       m_rd;
        logic       m_wr;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - opcode/flag inputs and datapath control outputs
interface mc_control_unit_if;
    logic [5:0] op;
    logic       zero;
    logic       PCWre;
    logic       IRWre;
    logic       InsMemRW;
    logic       RegWre;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic       ExtSel;
    logic [1:0] RegDst;
    logic       WrRegDSrc;
    logic       DBDataSrc;
    logic       mRD;
    logic       mWR;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;

    modport master (
        input  op, zero,
        output PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB, ExtSel,
               RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc, ALUOp
    );

    modport slave (
        output op, zero,
        input  PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB, ExtSel,
               RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc, ALUOp
    );
endinterface

// File: rtl/mc_decoder.sv
// rtl/mc_decoder.sv - opcode to instruction class and ALU operation
module mc_decoder
    import mc_pkg::*;
(
    input  logic [5:0] op_i,
    output cls_t       cls_o,
    output logic [2:0] alu_op_o
);

    always_comb begin
        cls_o    = CLS_NOP;
        alu_op_o = ALU_ADD;
        case (op_i)
            OP_ADD:   cls_o = CLS_RTYPE;
            OP_SUB:   begin cls_o = CLS_RTYPE; alu_op_o = ALU_SUB; end
            OP_AND:   begin cls_o = CLS_RTYPE; alu_op_o = ALU_AND; end
            OP_SLL:   begin cls_o = CLS_RTYPE; alu_op_o = ALU_SLL; end
            OP_SLT:   begin cls_o = CLS_RTYPE; alu_op_o = ALU_SLT; end
            OP_ADDIU: cls_o = CLS_ADDIU;
            OP_ORI:   begin cls_o = CLS_ORI; alu_op_o = ALU_OR; end
            OP_SW:    cls_o = CLS_SW;
            OP_LW:    cls_o = CLS_LW;
            OP_BEQ:   begin cls_o = CLS_BEQ; alu_op_o = ALU_SUB; end
            OP_BNE:   begin cls_o = CLS_BNE; alu_op_o = ALU_SUB; end
            OP_J:     cls_o = CLS_J;
            OP_JR:    cls_o = CLS_JR;
            OP_JAL:   cls_o = CLS_JAL;
            OP_HALT:  cls_o = CLS_HALT;
            default:  cls_o = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle control FSM driving datapath enables and selects
module mc_control_unit
    import mc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    mc_control_unit_if.master  bus
);

    state_t     state_q, state_d;
    cls_t       cls;
    logic [2:0] dec_alu_op;
    ctrl_t      ctrl, ctrl_out;

    mc_decoder u_decoder (
        .op_i     (bus.op),
        .cls_o    (cls),
        .alu_op_o (dec_alu_op)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IF: state_d = ST_ID;
            ST_ID: begin
                case (cls)
                    CLS_HALT:                      state_d = ST_HALT;
                    CLS_BEQ, CLS_BNE:              state_d = ST_EXE_BR;
                    CLS_LW, CLS_SW:                state_d = ST_EXE_LS;
                    CLS_RTYPE, CLS_ADDIU, CLS_ORI: state_d = ST_EXE_AL;
                    default:                       state_d = ST_IF;
                endcase
            end
            ST_EXE_AL: state_d = ST_WB_AL;
            ST_WB_AL:  state_d = ST_IF;
            ST_EXE_BR: state_d = ST_IF;
            ST_EXE_LS: state_d = ST_MEM;
            ST_MEM:    state_d = (cls == CLS_SW) ? ST_IF : ST_WB_LD;
            ST_WB_LD:  state_d = ST_IF;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IF;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_IF: begin
                ctrl.ins_mem_rw = 1'b1;
                ctrl.ir_wre     = 1'b1;
            end
            ST_ID: begin
                // Jumps and undefined opcodes retire here; everything else just decodes.
                case (cls)
                    CLS_J:  begin ctrl.pc_wre = 1'b1; ctrl.pc_src = PC_JUMP; end
                    CLS_JR: begin ctrl.pc_wre = 1'b1; ctrl.pc_src = PC_RS;   end
                    CLS_JAL: begin
                        ctrl.pc_wre       = 1'b1;
                        ctrl.pc_src       = PC_JUMP;
                        ctrl.reg_wre      = 1'b1;
                        ctrl.reg_dst      = RD_RA;
                        ctrl.wr_reg_d_src = 1'b0;
                    end
                    CLS_NOP: begin ctrl.pc_wre = 1'b1; ctrl.pc_src = PC_NEXT; end
                    default: ;
                endcase
            end
            ST_EXE_AL: begin
                ctrl.alu_op    = dec_alu_op;
                ctrl.alu_src_a = (dec_alu_op == ALU_SLL);
                ctrl.alu_src_b = (cls == CLS_ADDIU) || (cls == CLS_ORI);
                ctrl.ext_sel   = (cls == CLS_ADDIU);
            end
            ST_WB_AL: begin
                ctrl.reg_wre      = 1'b1;
                ctrl.wr_reg_d_src = 1'b1;
                ctrl.reg_dst      = (cls == CLS_RTYPE) ? RD_RD : RD_RT;
                ctrl.pc_wre       = 1'b1;
            end
            ST_EXE_BR: begin
                ctrl.alu_op  = ALU_SUB;
                ctrl.ext_sel = 1'b1;
                ctrl.pc_wre  = 1'b1;
                if ((cls == CLS_BEQ && bus.zero) || (cls == CLS_BNE && !bus.zero))
                    ctrl.pc_src = PC_BRANCH;
            end
            ST_EXE_LS: begin
                ctrl.alu_src_b = 1'b1;
                ctrl.ext_sel   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM: begin
                if (cls == CLS_SW) begin
                    ctrl.m_wr   = 1'b1;
                    ctrl.pc_wre = 1'b1;
                end else begin
                    ctrl.m_rd = 1'b1;
                end
            end
            ST_WB_LD: begin
                ctrl.m_rd         = 1'b1;
                ctrl.reg_wre      = 1'b1;
                ctrl.wr_reg_d_src = 1'b1;
                ctrl.db_data_src  = 1'b1;
                ctrl.reg_dst      = RD_RT;
                ctrl.pc_wre       = 1'b1;
            end
            default: ;
        endcase
    end

    // Gating with the reset pin makes every output drop the instant reset goes low.
    assign ctrl_out = reset ? ctrl : '0;

    assign bus.PCWre     = ctrl_out.pc_wre;
    assign bus.IRWre     = ctrl_out.ir_wre;
    assign bus.InsMemRW  = ctrl_out.ins_mem_rw;
    assign bus.RegWre    = ctrl_out.reg_wre;
    assign bus.ALUSrcA   = ctrl_out.alu_src_a;
    assign bus.ALUSrcB   = ctrl_out.alu_src_b;
    assign bus.ExtSel    = ctrl_out.ext_sel;
    assign bus.RegDst    = ctrl_out.reg_dst;
    assign bus.WrRegDSrc = ctrl_out.wr_reg_d_src;
    assign bus.DBDataSrc = ctrl_out.db_data_src;
    assign bus.mRD       = ctrl_out.m_rd;
    assign bus.mWR       = ctrl_out.m_wr;
    assign bus.PCSrc     = ctrl_out.pc_src;
    assign bus.ALUOp     = ctrl_out.alu_op;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - bench for mc_control_unit against a per-instruction cycle trace model
module tb_mc_control_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_control_unit_if bus ();

    mc_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {PCWre,IRWre,InsMemRW,RegWre,ALUSrcA,ALUSrcB,ExtSel,RegDst,WrRegDSrc,DBDataSrc,mRD,mWR,PCSrc,ALUOp}
    logic [17:0] obs;
    assign obs = {bus.PCWre, bus.IRWre, bus.InsMemRW, bus.RegWre, bus.ALUSrcA, bus.ALUSrcB,
                  bus.ExtSel, bus.RegDst, bus.WrRegDSrc, bus.DBDataSrc, bus.mRD, bus.mWR,
                  bus.PCSrc, bus.ALUOp};

    localparam logic [17:0] PCW  = 18'd1 << 17;
    localparam logic [17:0] IRW  = 18'd1 << 16;
    localparam logic [17:0] IMR  = 18'd1 << 15;
    localparam logic [17:0] REGW = 18'd1 << 14;
    localparam logic [17:0] SRCA = 18'd1 << 13;
    localparam logic [17:0] SRCB = 18'd1 << 12;
    localparam logic [17:0] EXT  = 18'd1 << 11;
    localparam logic [17:0] WRS  = 18'd1 << 8;
    localparam logic [17:0] DBS  = 18'd1 << 7;
    localparam logic [17:0] MRD  = 18'd1 << 6;
    localparam logic [17:0] MWR  = 18'd1 << 5;
    localparam logic [17:0] FETCH = IRW | IMR;

    function automatic logic [17:0] rd(input logic [1:0] v); return {7'd0, v, 9'd0}; endfunction
    function automatic logic [17:0] ps(input logic [1:0] v); return {13'd0, v, 3'd0}; endfunction
    function automatic logic [17:0] ao(input logic [2:0] v); return {15'd0, v}; endfunction

    typedef logic [17:0] trace_t [$];

    // Expected output word for every cycle of one instruction, fetch first.
    function automatic trace_t model(input logic [5:0] o, input logic z);
        trace_t q;
        logic [2:0] a;
        q.push_back(FETCH);
        case (o)
            6'b000000, 6'b000001, 6'b010000, 6'b011000, 6'b100111: begin
                a = (o == 6'b000001) ? 3'd1 : (o == 6'b010000) ? 3'd4 :
                    (o == 6'b011000) ? 3'd2 : (o == 6'b100111) ? 3'd5 : 3'd0;
                q.push_back('0);
                q.push_back(ao(a) | ((o == 6'b011000) ? SRCA : 18'd0));
                q.push_back(REGW | WRS | rd(2'b10) | PCW);
            end
            6'b000010: begin
                q.push_back('0);
                q.push_back(SRCB | EXT);
                q.push_back(REGW | WRS | rd(2'b01) | PCW);
            end
            6'b010010: begin
                q.push_back('0);
                q.push_back(SRCB | ao(3'd3));
                q.push_back(REGW | WRS | rd(2'b01) | PCW);
            end
            6'b110100, 6'b110101: begin
                q.push_back('0);
                q.push_back(ao(3'd1) | EXT | PCW |
                            ps(((o == 6'b110100) ? z : !z) ? 2'b01 : 2'b00));
            end
            6'b110001: begin
                q.push_back('0);
                q.push_back(SRCB | EXT);
                q.push_back(MRD);
                q.push_back(MRD | REGW | WRS | DBS | rd(2'b01) | PCW);
            end
            6'b110000: begin
                q.push_back('0);
                q.push_back(SRCB | EXT);
                q.push_back(MWR | PCW);
            end
            6'b111000: q.push_back(PCW | ps(2'b11));
            6'b111001: q.push_back(PCW | ps(2'b10));
            6'b111010: q.push_back(PCW | ps(2'b11) | REGW);
            6'b111111: q.push_back('0);
            default:   q.push_back(PCW);
        endcase
        return q;
    endfunction

    int passed = 0;
    int total  = 0;
    bit fresh  = 1'b0;

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %05h want %05h", name, act, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        check("reset_low_outputs", obs, 18'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        fresh = 1'b1;
    endtask

    // Runs one instruction from its IF cycle, sampling n cycles at the falling edge.
    task automatic run(input logic [5:0] o, input logic z, input int n, output trace_t tr);
        tr = {};
        if (!fresh) begin
            @(posedge clk);
            #1;
        end
        fresh   = 1'b0;
        bus.op   = o;
        bus.zero = z;
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            tr.push_back(obs);
        end
    endtask

    typedef struct {
        logic [5:0]  op;
        logic        zero;
        int          len;
        int          cyc;
        logic [17:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs [$];
    trace_t      tr, ex;
    logic [5:0]  ops [14];
    logic [5:0]  rop;
    logic        rz;
    int          n_pcw, n_regw, n_both;

    initial begin
        reset    = 1'b0;
        bus.op   = '0;
        bus.zero = 1'b0;

        vecs.push_back('{6'b000000, 1'b0, 4, 1, 18'd0,                            "add_id"});
        vecs.push_back('{6'b000000, 1'b0, 4, 2, ao(3'd0),                         "add_exe"});
        vecs.push_back('{6'b000000, 1'b0, 4, 3, REGW | WRS | rd(2'b10) | PCW,     "add_wb"});
        vecs.push_back('{6'b000001, 1'b0, 4, 2, ao(3'd1),                         "sub_exe"});
        vecs.push_back('{6'b011000, 1'b0, 4, 2, SRCA | ao(3'd2),                  "sll_exe"});
        vecs.push_back('{6'b010000, 1'b0, 4, 2, ao(3'd4),                         "and_exe"});
        vecs.push_back('{6'b100111, 1'b0, 4, 2, ao(3'd5),                         "slt_exe"});
        vecs.push_back('{6'b000010, 1'b0, 4, 2, SRCB | EXT,                       "addiu_exe"});
        vecs.push_back('{6'b000010, 1'b0, 4, 3, REGW | WRS | rd(2'b01) | PCW,     "addiu_wb"});
        vecs.push_back('{6'b010010, 1'b0, 4, 2, SRCB | ao(3'd3),                  "ori_exe"});
        vecs.push_back('{6'b110001, 1'b0, 5, 3, MRD,                              "lw_mem"});
        vecs.push_back('{6'b110001, 1'b0, 5, 4, MRD | REGW | WRS | DBS | rd(2'b01) | PCW, "lw_wb"});
        vecs.push_back('{6'b110000, 1'b0, 4, 2, SRCB | EXT,                       "sw_exe"});
        vecs.push_back('{6'b110000, 1'b0, 4, 3, MWR | PCW,                        "sw_mem"});
        vecs.push_back('{6'b110100, 1'b1, 3, 2, ao(3'd1) | EXT | PCW | ps(2'b01), "beq_taken"});
        vecs.push_back('{6'b110100, 1'b0, 3, 2, ao(3'd1) | EXT | PCW,             "beq_not"});
        vecs.push_back('{6'b110101, 1'b1, 3, 2, ao(3'd1) | EXT | PCW,             "bne_not"});
        vecs.push_back('{6'b110101, 1'b0, 3, 2, ao(3'd1) | EXT | PCW | ps(2'b01), "bne_taken"});
        vecs.push_back('{6'b111000, 1'b0, 2, 1, PCW | ps(2'b11),                  "j_id"});
        vecs.push_back('{6'b111001, 1'b0, 2, 1, PCW | ps(2'b10),                  "jr_id"});
        vecs.push_back('{6'b111010, 1'b0, 2, 1, PCW | ps(2'b11) | REGW,           "jal_id"});
        vecs.push_back('{6'b101010, 1'b0, 2, 1, PCW,                              "undef_nop"});

        ops = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010010, 6'b011000, 6'b100111,
                6'b110000, 6'b110001, 6'b110100, 6'b110101, 6'b111000, 6'b111001, 6'b111010};

        do_reset();

        foreach (vecs[i]) begin
            run(vecs[i].op, vecs[i].zero, vecs[i].len, tr);
            check({vecs[i].name, "_fetch"}, tr[0], FETCH);
            check(vecs[i].name, tr[vecs[i].cyc], vecs[i].exp);
        end

        // Random instruction stream against the trace model plus per-instruction invariants.
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 9) < 7) rop = ops[$urandom_range(0, 13)];
            else                          rop = 6'($urandom_range(0, 62));
            rz = 1'($urandom_range(0, 1));
            ex = model(rop, rz);
            run(rop, rz, ex.size(), tr);
            n_pcw = 0; n_regw = 0; n_both = 0;
            foreach (ex[c]) begin
                check($sformatf("rand%0d op=%b z=%0d cyc%0d", k, rop, rz, c), tr[c], ex[c]);
                n_pcw  += int'(tr[c][17]);
                n_regw += int'(tr[c][14]);
                n_both += int'(tr[c][6] & tr[c][5]);
            end
            check($sformatf("rand%0d pcwre_once", k), 18'(n_pcw), 18'd1);
            check($sformatf("rand%0d regwre_le1", k), 18'(n_regw > 1), 18'd0);
            check($sformatf("rand%0d mrd_mwr_excl", k), 18'(n_both), 18'd0);
        end

        // halt holds with all outputs low whatever op does, until reset.
        run(6'b111111, 1'b0, 2, tr);
        check("halt_fetch", tr[0], FETCH);
        check("halt_id", tr[1], 18'd0);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1 bus.op = ops[$urandom_range(0, 13)];
            @(negedge clk);
            check($sformatf("halt_hold%0d", c), obs, 18'd0);
        end
        do_reset();
        run(6'b000000, 1'b0, 4, tr);
        check("post_halt_if", tr[0], FETCH);
        check("post_halt_wb", tr[3], REGW | WRS | rd(2'b10) | PCW);

        // reset dropped in the middle of the sw memory cycle.
        run(6'b110000, 1'b0, 3, tr);
        @(posedge clk);
        #2 check("sw_mem_before_reset", obs, MWR | PCW);
        reset = 1'b0;
        #1 check("sw_async_reset", obs, 18'd0);
        do_reset();
        run(6'b110001, 1'b0, 5, tr);
        check("post_async_if", tr[0], FETCH);
        check("post_async_lw_wb", tr[4], MRD | REGW | WRS | DBS | rd(2'b01) | PCW);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have no parameters; all encodings come from the shared package.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 op  in  6  opcode from instruction register, stable from ID onward.
REQ-005 zero  in  1  ALU zero flag, valid in EXE_BR.
REQ-006 PCWre  out  1  PC load enable, one cycle per instruction.
REQ-007 IRWre  out  1  instruction register load enable.
REQ-008 InsMemRW  out  1  instruction memory read enable.
REQ-009 RegWre  out  1  register file write enable.
REQ-010 ALUSrcA  out  1  ALU A select: 0 = rs data, 1 = sa.
REQ-011 ALUSrcB  out  1  ALU B select: 0 = rt data, 1 = extended immediate.
REQ-012 ExtSel  out  1  immediate extension: 0 = zero, 1 = sign.
REQ-013 RegDst  out  2  write register: 00 = $31, 01 = rt, 10 = rd.
REQ-014 WrRegDSrc  out  1  write data: 0 = PC+4, 1 = DBDataSrc mux.
REQ-015 DBDataSrc  out  1  0 = ALU result, 1 = data memory output.
REQ-016 mRD  out  1  data memory read enable.
REQ-017 mWR  out  1  data memory write enable.
REQ-018 PCSrc  out  2  next PC: 00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs, 11 = jump target.
REQ-019 ALUOp  out  3  000 add, 001 sub, 010 sll (B<<A), 011 or, 100 and, 101 signed slt.

Function
REQ-020 Opcodes SHALL be: add 000000, sub 000001, addiu 000010, and 010000, ori 010010, sll 011000, slt 100111, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010, halt 111111.
REQ-021 States SHALL be: IF, ID, EXE_AL, WB_AL, EXE_BR, EXE_LS, MEM, WB_LD, HALT (4-bit encoding).
REQ-022 Outputs SHALL be a combinational function of the state and op; any output not listed for a state SHALL be 0.
REQ-023 IF: InsMemRW=1, IRWre=1; next state ID.
REQ-024 ID, j/jr/jal: PCWre=1, PCSrc=11/10/11; jal adds RegWre=1, RegDst=00, WrRegDSrc=0; next state IF (latency 2 cycles).
REQ-025 ID, halt: next state HALT. beq/bne: next state EXE_BR. lw/sw: next state EXE_LS. ALU opcodes: next state EXE_AL.
REQ-026 ID, undefined opcode: executes as a NOP, with PCWre=1 and PCSrc=00; next state IF.
REQ-027 EXE_AL: ALUOp per opcode; ALUSrcA=1 only for sll; ALUSrcB=1 and ExtSel=1 for addiu; ALUSrcB=1 and ExtSel=0 for ori; next state WB_AL.
REQ-028 WB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0, RegDst=10 for R-type (01 for addiu/ori), PCWre=1, PCSrc=00; next state IF (latency 4 cycles).
REQ-029 EXE_BR: ALUOp=001, ExtSel=1, PCWre=1; PCSrc=01 if (beq and zero) or (bne and not zero), else 00; next state IF (latency 3 cycles).
REQ-030 EXE_LS: ALUSrcB=1, ExtSel=1, ALUOp=000; next state MEM.
REQ-031 MEM: for sw, mWR=1, PCWre=1, PCSrc=00, next state IF (latency 4 cycles); for lw, mRD=1, next state WB_LD.
REQ-032 WB_LD: mRD=1, RegWre=1, WrRegDSrc=1, DBDataSrc=1, RegDst=01, PCWre=1, PCSrc=00; next state IF (latency 5 cycles).
REQ-033 HALT: all outputs 0; the state is held until reset.
REQ-034 PCWre and RegWre SHALL never assert more than once per instruction; mRD and mWR SHALL never assert together.

Reset
REQ-035 While reset is low, the state SHALL be IF and every output SHALL be forced to 0, including from HALT or mid-instruction.
REQ-036 The first rising clk edge after reset deasserts SHALL complete IF, with InsMemRW=1 and IRWre=1 during that cycle.

Structure
REQ-037 The package mc_pkg SHALL hold the state encoding, opcode constants, ALUOp, PCSrc and RegDst constants.
REQ-038 The sub-module mc_decoder SHALL map op to its instruction class and ALUOp; mc_control_unit SHALL hold the state register and output logic.

Verification
REQ-039 Scenario: add (op=000000) after reset -> states IF, ID, EXE_AL, WB_AL; RegWre=1, RegDst=10 and PCWre=1 only in WB_AL.
REQ-040 Scenario: lw (110001) -> 5 cycles; mRD=1 in MEM and WB_LD; DBDataSrc=1 in WB_LD; sw (110000) -> mWR=1 for exactly 1 cycle.
REQ-041 Scenario: beq with zero=1 -> PCSrc=01; beq with zero=0 -> PCSrc=00; bne inverts both; PCWre=1 in EXE_BR.
REQ-042 Scenario: jal (111010) -> in ID, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0; next state IF.
REQ-043 Scenario: halt (111111) -> HALT held for 20 cycles with all outputs 0; reset pulsed low -> IF.
REQ-044 Scenario: reset asserted in MEM of sw -> mWR drops to 0 immediately (asynchronously); undefined op 101010 -> NOP with PCWre=1 in ID.
